mpx_fm_modulator: RTL and testbench

- Parametrised successor of the 192 kHz FM stereo composite block.
- Once per sample strobe it builds the stereo multiplex from the sum channel, the pilot term (19 kHz sine × Kp) and the subcarrier term (difference channel × 38 kHz sine).
- It saturates the multiplex, scales it by the deviation gain Kf and presents a rounded, saturated FM deviation word with a one-cycle valid pulse.
- One shared shift-add multiplier, sequenced by an FSM, replaces the three separate multipliers and the ready-edge-triggered logic.

---
 rtl/mpx_fm_modulator.sv | 229 ++++++++++++++++++++++
 tb/tb_mpx_fm_modulator.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mpx_fm_modulator.sv
// rtl/mpx_fm_modulator.sv - FM stereo multiplex builder with one shared shift-add multiplier
module mpx_fm_modulator #(
  parameter int DW    = 18,
  parameter int SW    = 8,
  parameter int KPW   = 4,
  parameter int KFW   = 8,
  parameter int OW    = 24,
  parameter int ROUND = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clken,
  input  logic [DW-1:0]   sum_in,
  input  logic [DW-1:0]   diff_in,
  input  logic [SW-1:0]   sin19,
  input  logic [SW-1:0]   sin38,
  input  logic [KPW-1:0]  kp,
  input  logic [KFW-1:0]  kf,
  output logic [OW-1:0]   fm_out,
  output logic [DW:0]     mpx_out,
  output logic            out_valid,
  output logic            busy,
  output logic            overrun
);

  // Multiplier bit count covers the widest of the three multiplier operands.
  localparam int MW  = (KPW > SW) ? ((KPW > KFW) ? KPW : KFW) : ((SW > KFW) ? SW : KFW);
  localparam int CW  = $clog2(MW) + 1;
  // Accumulator is wide enough that the left-shifting multiplicand never overflows.
  localparam int AW  = DW + SW + KPW + KFW + 2;
  localparam int PSH = DW - SW - KPW;
  localparam int SSH = SW - 1;
  localparam int FSH = DW + 1 + KFW - OW;

  localparam logic [CW-1:0] KP_LAST = CW'(KPW - 1);
  localparam logic [CW-1:0] SW_LAST = CW'(SW - 1);
  localparam logic [CW-1:0] KF_LAST = CW'(KFW - 1);

  localparam logic signed [AW-1:0] SRND =
    (ROUND != 0 && SSH > 0) ? (AW'(1) << ((SSH > 0) ? SSH - 1 : 0)) : '0;
  localparam logic signed [AW-1:0] FRND =
    (ROUND != 0 && FSH > 0) ? (AW'(1) << ((FSH > 0) ? FSH - 1 : 0)) : '0;

  localparam logic signed [DW+1:0] M_MAX = {2'b00, {DW{1'b1}}};
  localparam logic signed [DW+1:0] M_MIN = {2'b11, {DW{1'b0}}};
  localparam logic signed [AW-1:0] O_MAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] O_MIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MUL_P, S_MUL_S, S_SUM, S_MUL_F, S_OUT
  } state_t;

  state_t state_q, state_d;

  logic signed [DW-1:0] sum_q,   sum_d;
  logic signed [DW-1:0] diff_q,  diff_d;
  logic signed [SW-1:0] sin19_q, sin19_d;
  logic signed [SW-1:0] sin38_q, sin38_d;
  logic [KPW-1:0]       kp_q,    kp_d;
  logic [KFW-1:0]       kf_q,    kf_d;
  logic signed [AW-1:0] acc_q,   acc_d;
  logic signed [AW-1:0] mcand_q, mcand_d;
  logic [MW-1:0]        mplier_q, mplier_d;
  logic [CW-1:0]        cnt_q,   cnt_d;
  logic signed [DW+1:0] p_q,     p_d;
  logic signed [DW+1:0] s_q,     s_d;
  logic signed [DW:0]   m_q,     m_d;
  logic signed [OW-1:0] fm_q,    fm_d;
  logic signed [DW:0]   mpx_q,   mpx_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;

  logic signed [AW-1:0] acc_step;
  logic signed [AW-1:0] prod_s;
  logic signed [DW+1:0] m_full;
  logic signed [DW:0]   m_sat;
  logic signed [AW-1:0] fm_full;
  logic [SW-1:0]        mag38;
  logic                 accept;

  // The output-valid cycle still belongs to the transaction, so a strobe there is refused.
  assign busy   = (state_q != S_IDLE) || valid_q;
  assign accept = (state_q == S_IDLE) && clken && !valid_q;

  // State and datapath registers; reset abandons any computation in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      sum_q     <= '0;
      diff_q    <= '0;
      sin19_q   <= '0;
      sin38_q   <= '0;
      kp_q      <= '0;
      kf_q      <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      p_q       <= '0;
      s_q       <= '0;
      m_q       <= '0;
      fm_q      <= '0;
      mpx_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      diff_q    <= diff_d;
      sin19_q   <= sin19_d;
      sin38_q   <= sin38_d;
      kp_q      <= kp_d;
      kf_q      <= kf_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      s_q       <= s_d;
      m_q       <= m_d;
      fm_q      <= fm_d;
      mpx_q     <= mpx_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state sequencing; each multiply phase lasts one cycle per multiplier bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_LOAD;
      S_LOAD:  state_d = S_MUL_P;
      S_MUL_P: if (cnt_q == KP_LAST) state_d = S_MUL_S;
      S_MUL_S: if (cnt_q == SW_LAST) state_d = S_SUM;
      S_SUM:   state_d = S_MUL_F;
      S_MUL_F: if (cnt_q == KF_LAST) state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: shared LSB-first shift-add step plus per-phase operand setup and post-processing.
  always_comb begin
    sum_d     = sum_q;
    diff_d    = diff_q;
    sin19_d   = sin19_q;
    sin38_d   = sin38_q;
    kp_d      = kp_q;
    kf_d      = kf_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    s_d       = s_q;
    m_d       = m_q;
    fm_d      = fm_q;
    mpx_d     = mpx_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q | (clken & busy);

    acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mag38    = sin38_q[SW-1] ? SW'(-sin38_q) : SW'(sin38_q);
    prod_s   = sin38_q[SW-1] ? -acc_step : acc_step;
    m_full   = (DW+2)'(sum_q) + p_q + s_q;
    if (m_full > M_MAX)      m_sat = (DW+1)'(M_MAX);
    else if (m_full < M_MIN) m_sat = (DW+1)'(M_MIN);
    else                     m_sat = (DW+1)'(m_full);
    fm_full  = (acc_q + FRND) >>> FSH;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sum_d   = sum_in;
          diff_d  = diff_in;
          sin19_d = sin19;
          sin38_d = sin38;
          kp_d    = kp;
          kf_d    = kf;
        end
      end
      S_LOAD: begin
        acc_d    = '0;
        mcand_d  = AW'(sin19_q);
        mplier_d = MW'(kp_q);
        cnt_d    = '0;
      end
      S_MUL_P, S_MUL_S, S_MUL_F: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q <<< 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (state_q == S_MUL_P && cnt_q == KP_LAST) begin
          // Pilot term done; the subcarrier multiply uses |sin38| and fixes the sign afterwards.
          p_d      = (DW+2)'(acc_step <<< PSH);
          acc_d    = '0;
          mcand_d  = AW'(diff_q);
          mplier_d = MW'(mag38);
          cnt_d    = '0;
        end
        if (state_q == S_MUL_S && cnt_q == SW_LAST) begin
          s_d = (DW+2)'((prod_s + SRND) >>> SSH);
        end
      end
      S_SUM: begin
        m_d      = m_sat;
        acc_d    = '0;
        mcand_d  = AW'(m_sat);
        mplier_d = MW'(kf_q);
        cnt_d    = '0;
      end
      S_OUT: begin
        if (fm_full > O_MAX)      fm_d = OW'(O_MAX);
        else if (fm_full < O_MIN) fm_d = OW'(O_MIN);
        else                      fm_d = OW'(fm_full);
        mpx_d   = m_q;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign fm_out    = fm_q;
  assign mpx_out   = mpx_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_mpx_fm_modulator.sv
// tb/tb_mpx_fm_modulator.sv - scoreboard bench for mpx_fm_modulator (ROUND=1 and ROUND=0 instances)
module tb_mpx_fm_modulator;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic               reset, clken, clken0;
  logic signed [17:0] sum_in, diff_in;
  logic signed [7:0]  sin19, sin38;
  logic [3:0]         kp;
  logic [7:0]         kf;
  logic signed [23:0] fm_out, fm_out0;
  logic signed [18:0] mpx_out, mpx_out0;
  logic               out_valid, busy, overrun;
  logic               out_valid0, busy0, overrun0;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    longint fm;
    longint mpx;
    longint cyc;
  } exp_t;

  exp_t q[$];
  exp_t q0[$];

  mpx_fm_modulator #(.ROUND(1)) dut (
    .clock(clock), .reset(reset), .clken(clken),
    .sum_in(sum_in), .diff_in(diff_in), .sin19(sin19), .sin38(sin38),
    .kp(kp), .kf(kf),
    .fm_out(fm_out), .mpx_out(mpx_out), .out_valid(out_valid),
    .busy(busy), .overrun(overrun)
  );

  mpx_fm_modulator #(.ROUND(0)) dut0 (
    .clock(clock), .reset(reset), .clken(clken0),
    .sum_in(sum_in), .diff_in(diff_in), .sin19(sin19), .sin38(sin38),
    .kp(kp), .kf(kf),
    .fm_out(fm_out0), .mpx_out(mpx_out0), .out_valid(out_valid0),
    .busy(busy0), .overrun(overrun0)
  );

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the rounding instance
  always @(negedge clock) begin
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("fm_out", fm_out, e.fm);
        chk("mpx_out", mpx_out, e.mpx);
        chk("latency", cyc, e.cyc);
      end
    end
  end

  // Monitor for the truncating instance
  always @(negedge clock) begin
    if (out_valid0) begin
      if (q0.size() == 0) begin
        chk("unexpected_valid_r0", 1, 0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("fm_out_r0", fm_out0, e.fm);
        chk("mpx_out_r0", mpx_out0, e.mpx);
        chk("latency_r0", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic wait_to(input int target);
    while (cyc < target) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_in(input int s, input int d, input int a19, input int a38, input int akp, input int akf);
    sum_in  = 18'(s);
    diff_in = 18'(d);
    sin19   = 8'(a19);
    sin38   = 8'(a38);
    kp      = 4'(akp);
    kf      = 8'(akf);
  endtask

  // Strobe one or both instances and record the expected results; called #1 after a rising edge.
  task automatic issue(input int s, input int d, input int a19, input int a38, input int akp, input int akf,
                       input longint efm, input longint empx, input bit both, input longint efm0);
    exp_t e;
    set_in(s, d, a19, a38, akp, akf);
    clken = 1'b1;
    e.fm = efm; e.mpx = empx; e.cyc = cyc + 24;
    q.push_back(e);
    if (both) begin
      clken0 = 1'b1;
      e.fm = efm0;
      q0.push_back(e);
    end
    @(posedge clock);
    #1;
    clken  = 1'b0;
    clken0 = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
  endtask

  // Strobe with no expected response
  task automatic poke(input int s, input int akf);
    set_in(s, 0, 0, 0, 0, akf);
    clken = 1'b1;
    @(posedge clock);
    #1;
    clken = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
  endtask

  task automatic run(input int s, input int d, input int a19, input int a38, input int akp, input int akf,
                     input longint efm, input longint empx);
    int st;
    st = cyc;
    issue(s, d, a19, a38, akp, akf, efm, empx, 1'b0, 0);
    wait_to(st + 26);
  endtask

  initial begin
    int st;
    reset  = 1'b0;
    clken  = 1'b0;
    clken0 = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clock);
    #1;
    chk("rst_fm", fm_out, 0);
    chk("rst_mpx", mpx_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Basic pass-through with latency and busy window
    st = cyc;
    issue(1000, 0, 0, 0, 0, 1, 125, 1000, 1'b0, 0);
    chk("busy_c1", busy, 1);
    wait_to(st + 24);
    chk("busy_c24", busy, 1);
    wait_to(st + 25);
    chk("busy_c25", busy, 0);
    chk("valid_c25", out_valid, 0);
    wait_to(st + 27);

    run(131071, 0, 0, 0, 0, 255, 4177888, 131071);
    run(131071, 131071, 127, 127, 15, 8, 262143, 262143);
    run(0, 0, 100, 0, 3, 1, 2400, 19200);
    run(-131072, -131072, -128, 127, 15, 255, -8355840, -262144);
    run(0, 0, 0, 0, 0, 0, 0, 0);

    // Rounding versus truncation on both instances
    st = cyc;
    issue(-3, 0, 0, 0, 0, 1, 0, -3, 1'b1, -1);
    wait_to(st + 26);
    st = cyc;
    issue(0, 128, 0, -128, 0, 1, -16, -128, 1'b1, -16);
    wait_to(st + 26);

    // Overrun: second strobe ignored, one result, later strobe accepted
    chk("overrun_pre", overrun, 0);
    st = cyc;
    issue(5000, 0, 0, 0, 0, 2, 1250, 5000, 1'b0, 0);
    wait_to(st + 10);
    poke(77, 1);
    chk("overrun_set", overrun, 1);
    wait_to(st + 30);
    st = cyc;
    issue(-2000, 0, 0, 0, 0, 3, -750, -2000, 1'b0, 0);
    chk("overrun_held", overrun, 1);
    wait_to(st + 26);

    // Reset in mid-computation
    st = cyc;
    poke(3000, 1);
    wait_to(st + 12);
    reset = 1'b0;
    #1;
    chk("midrst_fm", fm_out, 0);
    chk("midrst_mpx", mpx_out, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_overrun", overrun, 0);
    wait_to(st + 15);
    reset = 1'b1;
    wait_to(st + 40);
    st = cyc;
    issue(3000, 0, 0, 0, 0, 1, 375, 3000, 1'b0, 0);
    wait_to(st + 26);

    // Strobe during the output-valid cycle is an overrun
    chk("overrun_clr", overrun, 0);
    st = cyc;
    issue(8, 0, 0, 0, 0, 1, 1, 8, 1'b0, 0);
    wait_to(st + 24);
    poke(9, 1);
    wait_to(st + 60);
    chk("overrun_out_cycle", overrun, 1);

    chk("sb_empty", q.size(), 0);
    chk("sb0_empty", q0.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
